// File: rtl/spi_ram_pkg.sv
// Shared definitions for the external SPI RAM engines: command opcodes, frame geometry, FSM encoding.
package spi_ram_pkg;

    localparam logic [7:0] SPI_CMD_READ  = 8'h03;
    localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

    localparam int HDR_BITS   = 24;
    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = HDR_BITS + DATA_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2,
        GAP  = 2'd3
    } spi_state_t;

    function automatic logic [FRAME_BITS-1:0] write_frame(input logic [15:0] a, input logic [7:0] d);
        return {SPI_CMD_WRITE, a, d};
    endfunction

endpackage

// File: rtl/spi_write_byte.sv
// Single-byte write to a 23LC512-style SPI RAM (cmd 0x02, 16-bit address, 8 data bits, mode 0, MSB first).
// Start-to-done latency 65 clk; start is ignored while busy; busy also covers the cs_n high gap.
module spi_write_byte
    import spi_ram_pkg::*;
#(
    parameter int CS_HIGH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] addr,
    input  logic [7:0]  data_in,
    output logic        busy,
    output logic        done,
    output logic        cs_n,
    output logic        sck,
    output logic        mosi
);

    localparam int GAP_LAST = (CS_HIGH_CYCLES > 1) ? CS_HIGH_CYCLES - 2 : 0;
    localparam int GW       = (GAP_LAST < 1) ? 1 : $clog2(GAP_LAST + 1);

    spi_state_t              state, state_nxt;
    logic                    phase, phase_nxt;
    logic [5:0]              bit_cnt, bit_cnt_nxt;
    logic [FRAME_BITS-1:0]   shreg, shreg_nxt;
    logic [GW-1:0]           gap_cnt, gap_cnt_nxt;
    logic                    cs_n_nxt, sck_nxt, mosi_nxt, busy_nxt, done_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            phase   <= 1'b0;
            bit_cnt <= '0;
            shreg   <= '0;
            gap_cnt <= '0;
            cs_n    <= 1'b1;
            sck     <= 1'b0;
            mosi    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            phase   <= phase_nxt;
            bit_cnt <= bit_cnt_nxt;
            shreg   <= shreg_nxt;
            gap_cnt <= gap_cnt_nxt;
            cs_n    <= cs_n_nxt;
            sck     <= sck_nxt;
            mosi    <= mosi_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        phase_nxt   = phase;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        gap_cnt_nxt = gap_cnt;
        cs_n_nxt    = cs_n;
        sck_nxt     = sck;
        mosi_nxt    = mosi;
        busy_nxt    = busy;
        done_nxt    = 1'b0;

        case (state)
            IDLE: begin
                cs_n_nxt = 1'b1;
                sck_nxt  = 1'b0;
                if (start) begin
                    shreg_nxt   = write_frame(addr, data_in);
                    bit_cnt_nxt = 6'(FRAME_BITS);
                    phase_nxt   = 1'b0;
                    cs_n_nxt    = 1'b0;
                    busy_nxt    = 1'b1;
                    state_nxt   = SEND;
                end
            end
            SEND: begin
                // Phase bit halves clk: present data with sck low, then raise sck a period later.
                if (!phase) begin
                    sck_nxt   = 1'b0;
                    mosi_nxt  = shreg[FRAME_BITS-1];
                    phase_nxt = 1'b1;
                end else begin
                    sck_nxt     = 1'b1;
                    shreg_nxt   = {shreg[FRAME_BITS-2:0], 1'b0};
                    bit_cnt_nxt = bit_cnt - 6'd1;
                    phase_nxt   = 1'b0;
                    if (bit_cnt == 6'd1) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                sck_nxt     = 1'b0;
                mosi_nxt    = 1'b0;
                cs_n_nxt    = 1'b1;
                done_nxt    = 1'b1;
                gap_cnt_nxt = '0;
                if (CS_HIGH_CYCLES > 1) begin
                    state_nxt = GAP;
                end else begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                end
            end
            GAP: begin
                cs_n_nxt = 1'b1;
                if (gap_cnt == GW'(GAP_LAST)) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                end else begin
                    gap_cnt_nxt = gap_cnt + GW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cs_n_nxt  = 1'b1;
                sck_nxt   = 1'b0;
                mosi_nxt  = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_write_byte.sv
// Randomised scoreboard bench for spi_write_byte: stimulus pushes expected frames, a monitor decodes the SPI pins.
module tb_spi_write_byte;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start4 = 1'b0;
    logic [15:0] addr = 16'h0;
    logic [7:0]  data_in = 8'h0;
    logic        busy, done, cs_n, sck, mosi;
    logic        busy4, done4, cs_n4, sck4, mosi4;

    int errors = 0;
    int checks = 0;
    int exp_gap = 0;
    int aborted = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    spi_write_byte #(.CS_HIGH_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .data_in(data_in),
        .busy(busy), .done(done), .cs_n(cs_n), .sck(sck), .mosi(mosi)
    );

    spi_write_byte #(.CS_HIGH_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .addr(addr), .data_in(data_in),
        .busy(busy4), .done(done4), .cs_n(cs_n4), .sck(sck4), .mosi(mosi4)
    );

    // Reference: a write frame is simply the opcode, then address, then data, MSB first.
    function automatic logic [31:0] model_frame(input logic [15:0] a, input logic [7:0] d);
        return {8'h02, a, d};
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Issue one write; optionally poke start/addr/data_in mid-frame, which must not alter it.
    task automatic do_write(input logic [15:0] a, input logic [7:0] d, input bit immune);
        start = 1'b1;
        addr = a;
        data_in = d;
        tick();
        exp_q.push_back(model_frame(a, d));
        start = 1'b0;
        if (immune) begin
            for (int k = 1; k <= 45; k++) begin
                if (k == 10 || k == 40) begin
                    start = 1'b1;
                    addr = 16'($urandom);
                    data_in = 8'($urandom);
                end else begin
                    start = 1'b0;
                end
                tick();
            end
            start = 1'b0;
        end
        wait_idle();
    endtask

    // Monitor: decode bits on sck rises while cs_n is low, compare at the end of each frame.
    logic        prev_cs = 1'b1;
    logic        prev_sck = 1'b0;
    logic [31:0] cap = 32'h0;
    int          nbits = 0;
    int          low_len = 0;
    int          high_len = 0;

    always @(negedge clk) begin
        if (cs_n && !prev_cs) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", cap, 32'hx);
                end else begin
                    check("frame", cap, exp_q.pop_front());
                end
                check("bit_count", 32'(nbits), 32'd32);
                check("cs_low_len", 32'(low_len), 32'd65);
                check("end_lines", {30'd0, sck, mosi}, 32'd0);
            end else begin
                aborted++;
            end
            high_len = 1;
        end else begin
            if (done) check("stray_done", 32'(done), 32'd0);
            if (!cs_n && prev_cs) begin
                if (exp_gap > 0) check("cs_high_gap", 32'(high_len), 32'(exp_gap));
                nbits = 0;
                cap = 32'h0;
                low_len = 1;
            end else if (!cs_n) begin
                low_len++;
            end else begin
                high_len++;
            end
            if (!cs_n && sck && !prev_sck) begin
                cap = {cap[30:0], mosi};
                nbits++;
            end
        end
        prev_cs = cs_n;
        prev_sck = sck;
    end

    logic c4[0:80];
    logic b4[0:80];
    logic d4[0:80];

    initial begin
        repeat (3) tick();
        check("reset_outputs", {27'd0, cs_n, sck, mosi, busy, done}, 32'b10000);
        rst_n = 1'b1;
        tick();

        do_write(16'h1234, 8'hA5, 1'b0);
        do_write(16'hFFFF, 8'h00, 1'b0);
        do_write(16'h0000, 8'hFF, 1'b0);

        // start held high: second accept one cycle after the first frame ends
        start = 1'b1;
        addr = 16'hBEEF;
        data_in = 8'h3C;
        tick();
        exp_q.push_back(model_frame(16'hBEEF, 8'h3C));
        tick();
        exp_gap = 1;
        repeat (65) tick();
        exp_q.push_back(model_frame(16'hBEEF, 8'h3C));
        start = 1'b0;
        wait_idle();
        tick();
        exp_gap = 0;

        do_write(16'h5A5A, 8'hC3, 1'b1);

        // Reset lands on E20 of a frame that must then be abandoned
        start = 1'b1;
        addr = 16'h7777;
        data_in = 8'h11;
        tick();
        start = 1'b0;
        repeat (19) tick();
        rst_n = 1'b0;
        tick();
        check("reset_mid_frame", {27'd0, cs_n, sck, mosi, busy, done}, 32'b10000);
        rst_n = 1'b1;
        tick();
        tick();

        do_write(16'h0F0F, 8'h96, 1'b0);

        // CS_HIGH_CYCLES=4 instance, start held for two frames
        start4 = 1'b1;
        addr = 16'h2468;
        data_in = 8'h81;
        tick();
        c4[0] = cs_n4; b4[0] = busy4; d4[0] = done4;
        for (int k = 1; k <= 80; k++) begin
            tick();
            c4[k] = cs_n4; b4[k] = busy4; d4[k] = done4;
            if (k == 69) start4 = 1'b0;
        end
        check("cs4_low_e0", 32'(c4[0]), 32'd0);
        check("cs4_low_e64", 32'(c4[64]), 32'd0);
        for (int k = 65; k <= 68; k++) check("cs4_high_gap", 32'(c4[k]), 32'd1);
        check("cs4_refall_e69", 32'(c4[69]), 32'd0);
        check("busy4_e67", 32'(b4[67]), 32'd1);
        check("busy4_e68", 32'(b4[68]), 32'd0);
        check("busy4_e69", 32'(b4[69]), 32'd1);
        check("done4_e65", 32'(d4[65]), 32'd1);
        check("done4_e66", 32'(d4[66]), 32'd0);
        begin
            bit ok4 = 1'b0;
            for (int i = 0; i < 300; i++) begin
                if (!busy4) begin
                    ok4 = 1'b1;
                    break;
                end
                tick();
            end
            if (!ok4) check("idle4_timeout", 32'(busy4), 32'd0);
        end

        for (int n = 0; n < 12; n++) begin
            do_write(16'($urandom), 8'($urandom), bit'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) tick();
        end

        repeat (5) tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("aborted_frames", 32'(aborted), 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_write_byte.md
# spi_write_byte

Writes exactly one byte to the 23LC512-style external SPI RAM using command 0x02, a 16-bit address and 8 data bits, MSB first, SPI mode 0. It is the write-side companion of the CPU's single-byte SPI read engine and shares the CS_N/SCK/MOSI pins with it through the top-level arbiter. The CPU issues `start` with `addr` and `data_in`, then waits for `done`. `busy` stays high until the minimum chip-select-high gap has elapsed.

## Interface
- CS_HIGH_CYCLES, default 1: minimum clk periods `cs_n` stays high after a transaction before the next one may begin; legal range ≥1.
- clk  input  1  system clock; SCK = clk/2 while shifting.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request; sampled only in IDLE; level or pulse.
- addr  input  16  RAM address; latched on the accepting edge.
- data_in  input  8  byte to write; latched on the accepting edge.
- busy  output  1  high from the accepting edge until the block returns to IDLE.
- done  output  1  one-clk pulse when the write frame has completed.
- cs_n  output  1  active-low chip select.
- sck  output  1  SPI clock; idles low.
- mosi  output  1  serial data out.

## Operation
- States:
  - IDLE: `cs_n`=1, `sck`=0. On `start`, latch the 32-bit frame {0x02, addr, data_in} into the shift register, set the bit counter to 32, drive `cs_n`=0 and `busy`=1, then go to SEND.
  - SEND: alternates a phase bit.
    - Phase 0: `sck`<=0 and `mosi`<=frame[31].
    - Phase 1: `sck`<=1, shift the frame left, decrement the counter.
    - After phase 1 of the bit with counter==1, go to DONE.
  - DONE: `sck`<=0, `mosi`<=0, `cs_n`<=1, `done`<=1. Go to GAP if CS_HIGH_CYCLES>1, else to IDLE with `busy`<=0.
  - GAP: count CS_HIGH_CYCLES-1 cycles with `cs_n`=1 and `busy`=1, then go to IDLE with `busy`<=0.
  - Illegal state: go to IDLE.
- Input changes while busy:
  - `start` is ignored while busy.
  - `addr` and `data_in` changes after the accepting edge have no effect on the frame.
- Counter and phase:
  - Bit counter is 6 bits wide.
  - The phase bit is the only clock divider; no other prescaler.
- Reset behaviour:
  - Reset values: `cs_n`=1, `sck`=0, `mosi`=0, `busy`=0, `done`=0; state=IDLE, counter=0, shift register=0.
  - Reset asserted mid-frame aborts on that edge with the same values. No `done` is issued, and the partial frame is not retried.

## Timing
- Let E0 be the edge at which `start` is accepted.
  - E0: `cs_n`=0, `busy`=1.
  - E1: `mosi`=bit31 (MSB of 0x02), `sck`=0.
  - E2: `sck`=1. The RAM samples on this rising edge.
  - Bit k (k=0 for the MSB): `mosi` updates at E(2k+1); `sck` rises at E(2k+2).
  - E64: last SCK rise (data_in[0]).
  - E65: `sck`=0, `mosi`=0, `cs_n`=1, `done`=1.
  - E66: `done`=0.
- `busy` falls at E(64+CS_HIGH_CYCLES). The earliest next accepting edge is E(65+CS_HIGH_CYCLES), so `cs_n` is high for ≥CS_HIGH_CYCLES periods.
- MOSI setup and hold to the SCK rise are each one clk period. `cs_n` leads the first SCK rise by 2 periods.
- Latency from start to done is 65 clk. Throughput is one byte per 65+CS_HIGH_CYCLES clk with `start` held high.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `spi_ram_pkg`:
  - SPI_CMD_READ=8'h03, SPI_CMD_WRITE=8'h02.
  - Frame lengths (24-bit header, 8-bit data).
  - State encoding constants IDLE/SEND/DONE/GAP.
- Single module; no sub-module. Control FSM and SCK/MOSI output registers sit in one clocked process on `clk`.

## Test plan
- Single write: addr=0x1234, data_in=0xA5.
  - MOSI bits sampled on SCK rises form 0x02,0x12,0x34,0xA5 (32 rises).
  - `done` at E65 only; `cs_n` low E0–E64.
- Boundary values: addr=0xFFFF, data_in=0x00 -> header 0x02FFFF followed by eight 0s; then addr=0x0000, data_in=0xFF -> 0x020000FF.
- Back-to-back: `start` held high, two frames, CS_HIGH_CYCLES=1 -> second `cs_n` fall at E66, `cs_n` high exactly 1 period; CS_HIGH_CYCLES=4 -> `cs_n` high 4 periods, `busy` low at E68.
- Busy immunity: `start` pulses and addr/data_in changes at E10 and E40 -> frame unchanged, single `done`.
- Reset mid-frame: `rst_n`=0 at E20 -> next edge `cs_n`=1, `sck`=0, `mosi`=0, `busy`=0, no `done`; a fresh write afterwards is correct.
